// File: rtl/ibus_responder_pkg.sv
// rtl/ibus_responder_pkg.sv - shared constants, state encoding and segment helper for the fetch responder
package ibus_responder_pkg;

   localparam logic [31:0] KSEG0_BASE   = 32'h8000_0000;
   localparam logic [31:0] KSEG1_BASE   = 32'hA000_0000;
   localparam logic [31:0] SEG_MASK     = 32'hE000_0000;
   localparam int          PHYS_W       = 29;
   localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   function automatic logic in_seg(input logic [31:0] addr, input logic [31:0] base);
      return (addr & SEG_MASK) == base;
   endfunction

endpackage

// File: rtl/ibus_addr_decode.sv
// rtl/ibus_addr_decode.sv - combinational kseg0/kseg1 decode of a fetch address
module ibus_addr_decode
   import ibus_responder_pkg::*;
(
   input  logic [31:0]       address,
   output logic              mapped,
   output logic              aligned,
   output logic [PHYS_W-1:0] phys
);

   // Both unmapped-cached and unmapped-uncached windows alias the same physical space.
   assign mapped  = in_seg(address, KSEG0_BASE) | in_seg(address, KSEG1_BASE);
   assign aligned = (address[1:0] == 2'b00);
   assign phys    = address[PHYS_W-1:0];

endmodule

// File: rtl/ibus_responder.sv
// rtl/ibus_responder.sv - single-outstanding instruction fetch responder with backend timeout
module ibus_responder
   import ibus_responder_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       ibus_address,
   input  logic              ibus_read,
   output logic [31:0]       ibus_data,
   output logic              ibus_stall,
   output logic              ibus_error,
   output logic              mem_req,
   output logic [PHYS_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [0:0]        state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [31:0]       data_q, data_d;
   logic              err_q, err_d;
   logic [PHYS_W-1:0] addr_q, addr_d;

   logic              dec_mapped;
   logic              dec_aligned;
   logic [PHYS_W-1:0] dec_phys;

   ibus_addr_decode u_decode (
      .address (ibus_address),
      .mapped  (dec_mapped),
      .aligned (dec_aligned),
      .phys    (dec_phys)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      err_d   = err_q;
      addr_d  = addr_q;
      if (state_q == ST_IDLE) begin
         // An error response lasts one cycle; data is held until the next accept.
         err_d = 1'b0;
         if (ibus_read) begin
            if (dec_mapped && dec_aligned) begin
               state_d = ST_BUSY;
               cnt_d   = 8'd0;
               addr_d  = dec_phys;
            end else begin
               err_d  = 1'b1;
               data_d = 32'd0;
            end
         end
      end else begin
         // Ack wins over a coincident timeout.
         if (mem_ack) begin
            state_d = ST_IDLE;
            data_d  = mem_rdata;
            err_d   = 1'b0;
         end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = ST_IDLE;
            data_d  = 32'd0;
            err_d   = 1'b1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         data_q  <= 32'd0;
         err_q   <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
      end
   end

   assign ibus_stall = (state_q == ST_BUSY);
   assign mem_req    = (state_q == ST_BUSY);
   assign mem_addr   = addr_q;
   assign ibus_data  = data_q;
   assign ibus_error = err_q;

endmodule
